mul_share_arb: RTL and testbench



---
 rtl/invsqrt_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/mul_share_arb.sv | 101 ++++++++++
 tb/tb_mul_share_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/invsqrt_pkg.sv
// Shared constants and types for the invsqrt datapath: multiplier widths,
// requester IDs and the tag carried alongside each product.
package invsqrt_pkg;

    localparam int unsigned MUL_A_W     = 47;
    localparam int unsigned MUL_B_W     = 41;
    localparam int unsigned MUL_P_W     = MUL_A_W + MUL_B_W;
    localparam int unsigned MUL_LAT_DEF = 2;
    localparam int unsigned ID_MAX_W    = 3;

    typedef enum logic [1:0] {
        ID_YY  = 2'd0,
        ID_AY2 = 2'd1,
        ID_A3Y = 2'd2
    } req_id_e;

    typedef struct packed {
        logic                v;
        logic [ID_MAX_W-1:0] id;
    } mul_tag_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the last winner + 1 with wrap-around,
// producing a one-hot grant and the encoded winner index.
module rr_arbiter
    import invsqrt_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            advance,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  idx_c
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;
    logic           found;

    // First requester after the pointer wins; pointer itself is searched last.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx_c = cand;
            end
        end
        if (en && found) begin
            grant_c = NREQ'(1) << idx_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDW'(NREQ - 1);
        end else if (advance) begin
            ptr <= idx_c;
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Time-shares one pipelined multiplier between NREQ requesters and steers
// each product back to its requester as a one-hot response strobe.
module mul_share_arb
    import invsqrt_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned ASIZE   = MUL_A_W,
    parameter int unsigned BSIZE   = MUL_B_W,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned IDW     = id_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ASIZE-1:0]   req_a,
    input  logic [NREQ*BSIZE-1:0]   req_b,
    output logic                    mul_ce,
    output logic [ASIZE-1:0]        mul_a,
    output logic [BSIZE-1:0]        mul_b,
    input  logic [ASIZE+BSIZE-1:0]  mul_p,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [ASIZE+BSIZE-1:0]  rsp_p,
    output logic                    busy
);

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_idx;
    logic             xfer;
    logic [ASIZE-1:0] sel_a;
    logic [BSIZE-1:0] sel_b;
    mul_tag_t         tag_in;
    logic             inflight;

    // tag_q[0] rides with the operand register; tag_q[1..MUL_LAT] shadow the multiplier stages.
    mul_tag_t tag_q [MUL_LAT+1];

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (en),
        .advance (xfer),
        .grant_c (grant),
        .idx_c   (win_idx)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    // Operand mux and stage-0 tag for the current winner.
    always_comb begin
        sel_a  = req_a[32'(win_idx)*ASIZE +: ASIZE];
        sel_b  = req_b[32'(win_idx)*BSIZE +: BSIZE];
        tag_in = '0;
        if (xfer) begin
            tag_in.v  = 1'b1;
            tag_in.id = ID_MAX_W'(win_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_ce    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
            for (int unsigned i = 0; i <= MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mul_ce <= 1'b1;
            if (xfer) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
            end
            tag_q[0] <= tag_in;
            for (int unsigned i = 1; i <= MUL_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rsp_valid <= tag_q[MUL_LAT].v ? (NREQ'(1) << tag_q[MUL_LAT].id) : '0;
            if (tag_q[MUL_LAT].v) begin
                rsp_p <= mul_p;
            end
        end
    end

    always_comb begin
        inflight = 1'b0;
        for (int unsigned i = 0; i <= MUL_LAT; i++) begin
            inflight = inflight | tag_q[i].v;
        end
        busy = xfer | inflight | (|rsp_valid);
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized and directed bench for mul_share_arb against a queue-based
// reference model, with a behavioural two-stage multiplier attached.
module tb_mul_share_arb;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned ASIZE   = 47;
    localparam int unsigned BSIZE   = 41;
    localparam int unsigned PW      = ASIZE + BSIZE;
    localparam int unsigned MUL_LAT = 2;
    localparam int          RSP_LAT = MUL_LAT + 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ASIZE-1:0] req_a;
    logic [NREQ*BSIZE-1:0] req_b;
    logic                  mul_ce;
    logic [ASIZE-1:0]      mul_a;
    logic [BSIZE-1:0]      mul_b;
    logic [PW-1:0]         mul_p;
    logic [NREQ-1:0]       rsp_valid;
    logic [PW-1:0]         rsp_p;
    logic                  busy;

    mul_share_arb #(
        .NREQ    (NREQ),
        .ASIZE   (ASIZE),
        .BSIZE   (BSIZE),
        .MUL_LAT (MUL_LAT),
        .IDW     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: input register then product register.
    logic [ASIZE-1:0] xa;
    logic [BSIZE-1:0] xb;
    always @(posedge clk) begin
        if (mul_ce) begin
            xa    <= mul_a;
            xb    <= mul_b;
            mul_p <= PW'(xa) * PW'(xb);
        end
    end

    typedef struct {
        int            due;
        int            id;
        logic [PW-1:0] p;
    } exp_t;

    exp_t             q[$];
    int               m_ptr;
    int               cyc;
    int               n_vec;
    int               n_err;
    logic [ASIZE-1:0] op_a [NREQ];
    logic [BSIZE-1:0] op_b [NREQ];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, update the model.
    task automatic cycle_step(input logic [NREQ-1:0] v, input logic e);
        int            win;
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] ev;
        logic          xf;
        exp_t          ent;
        @(negedge clk);
        req_valid = v;
        en        = e;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*ASIZE +: ASIZE] = op_a[i];
            req_b[i*BSIZE +: BSIZE] = op_b[i];
        end
        #1;
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (win < 0 && v[i]) win = i;
        end
        er = '0;
        if (e && win >= 0) er[win] = 1'b1;
        xf = (er != '0);
        check_eq("req_ready", 128'(req_ready), 128'(er));
        check_eq("busy", 128'(busy), 128'(xf || q.size() > 0));
        check_eq("mul_ce", 128'(mul_ce), 128'(1));
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = '0;
            ev[q[0].id] = 1'b1;
            check_eq("rsp_valid", 128'(rsp_valid), 128'(ev));
            check_eq("rsp_p", 128'(rsp_p), 128'(q[0].p));
            void'(q.pop_front());
        end else begin
            check_eq("rsp_idle", 128'(rsp_valid), 128'(0));
        end
        if (xf) begin
            ent.due = cyc + RSP_LAT;
            ent.id  = win;
            ent.p   = PW'(op_a[win]) * PW'(op_b[win]);
            q.push_back(ent);
            m_ptr = win;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check_eq("rst_ready", 128'(req_ready), 128'(0));
        check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_mul_a", 128'(mul_a), 128'(0));
        check_eq("rst_mul_b", 128'(mul_b), 128'(0));
        check_eq("rst_rsp_p", 128'(rsp_p), 128'(0));
        check_eq("rst_mul_ce", 128'(mul_ce), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_ptr = NREQ - 1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle_step('0, 1'b1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        m_ptr     = NREQ - 1;
        rst_n     = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        #2;
        apply_reset();

        // Single product 3*5.
        op_a[0] = ASIZE'(3);
        op_b[0] = BSIZE'(5);
        cycle_step(3'b001, 1'b1);
        drain(6);

        // All three requesters continuously, operands (i, i+1).
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = ASIZE'(i);
            op_b[i] = BSIZE'(i + 1);
        end
        for (int i = 0; i < 9; i++) cycle_step(3'b111, 1'b1);
        drain(6);

        // Full-scale operands: no truncation of the 88-bit product.
        op_a[1] = '1;
        op_b[1] = '1;
        cycle_step(3'b010, 1'b1);
        drain(6);

        // en held low mid-stream.
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = ASIZE'(100 + i);
            op_b[i] = BSIZE'(7 * i + 9);
        end
        for (int i = 0; i < 2; i++) cycle_step(3'b111, 1'b1);
        for (int i = 0; i < 3; i++) cycle_step(3'b111, 1'b0);
        for (int i = 0; i < 3; i++) cycle_step(3'b111, 1'b1);
        drain(6);

        // Reset with two products in flight; the next grant returns to requester 0.
        cycle_step(3'b111, 1'b1);
        cycle_step(3'b111, 1'b1);
        apply_reset();
        cycle_step(3'b111, 1'b1);
        drain(6);

        // Sole requester 2, back-to-back.
        for (int i = 0; i < 4; i++) begin
            op_a[2] = ASIZE'(1000 + i);
            op_b[2] = BSIZE'(3 + i);
            cycle_step(3'b100, 1'b1);
        end
        drain(6);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = ASIZE'({$urandom(), $urandom()});
                op_b[i] = BSIZE'({$urandom(), $urandom()});
            end
            cycle_step(NREQ'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0));
        end
        drain(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
